// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time clock: field limits, field widths,
// the time-of-day payload struct and small helpers on it.
package rtc_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    // Internal time is always held in 24h form.
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } tod_t;

    // True when every field is inside its legal range.
    function automatic logic tod_in_range(input tod_t t);
        return (t.hour <= HOUR_W'(HOUR_MAX)) &&
               (t.min  <= MIN_W'(MIN_MAX))   &&
               (t.sec  <= SEC_W'(SEC_MAX));
    endfunction

    // One-second advance with sec->min->hour carries and midnight wrap.
    function automatic tod_t tod_advance(input tod_t t);
        tod_t r;
        r = t;
        if (t.sec == SEC_W'(SEC_MAX)) begin
            r.sec = '0;
            if (t.min == MIN_W'(MIN_MAX)) begin
                r.min = '0;
                if (t.hour == HOUR_W'(HOUR_MAX)) begin
                    r.hour = '0;
                end else begin
                    r.hour = t.hour + HOUR_W'(1);
                end
            end else begin
                r.min = t.min + MIN_W'(1);
            end
        end else begin
            r.sec = t.sec + SEC_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Seconds prescaler: counts run-enabled cycles 0..TICK_DIV-1 and raises a
// registered one-cycle tick after the cycle in which the count wraps.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   run   - 1 = count, 0 = hold count and keep tick low
//   clear - synchronous restart of the count; drops any pending tick
//   tick  - one-cycle pulse per TICK_DIV run cycles
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    // A divide-by-one counter still needs one bit to exist.
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count register and registered tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == CNT_MAX) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock timekeeper: 24h internal hh:mm:ss registers advanced by a
// prescaled seconds tick, a valid/ready time-load port with range checking,
// a 12h/24h display mapping and an optional hh:mm alarm.
// Optional feature macro: CLOCK_ALARM_EN (alarm registers and alarm_fire).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   run               - 1 = timekeeping advances
//   mode_24h          - 1 = 24h display, 0 = 12h display
//   load_valid/ready  - time-load handshake; load_hours/minutes/seconds payload
//   load_err          - pulse after a handshake with an out-of-range field
//   hours/minutes/seconds/am_pm - displayed time
//   sec_tick          - pulse on each second advance
//   alarm_wr/alarm_hours/alarm_minutes/alarm_arm/alarm_fire - alarm interface
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [4:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    output logic       load_err,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       am_pm,
    output logic       sec_tick,
    input  logic       alarm_wr,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_arm,
    output logic       alarm_fire
);

    localparam logic [HOUR_W-1:0] NOON = HOUR_W'(12);

    tod_t tod_q;
    tod_t tod_adv;
    tod_t load_tod;
    logic load_fire;
    logic load_ok;
    logic load_take;

    assign load_tod  = '{hour: load_hours, min: load_minutes, sec: load_seconds};
    assign load_fire = load_valid && load_ready;
    assign load_ok   = tod_in_range(load_tod);
    assign load_take = load_fire && load_ok;
    assign tod_adv   = tod_advance(tod_q);

    // A successful load restarts the second; a rejected one leaves it alone.
    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (load_take),
        .tick  (sec_tick)
    );

    // Time registers, load handshake and error pulse; a load beats a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tod_q      <= '{hour: HOUR_W'(RESET_HOUR), min: '0, sec: '0};
            load_ready <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_ready <= 1'b1;
            load_err   <= load_fire && !load_ok;
            if (load_take) begin
                tod_q <= load_tod;
            end else if (sec_tick) begin
                tod_q <= tod_adv;
            end
        end
    end

    // Display mapping follows mode_24h immediately without touching time.
    always_comb begin
        minutes = tod_q.min;
        seconds = tod_q.sec;
        am_pm   = (tod_q.hour >= NOON);
        hours   = tod_q.hour;
        if (!mode_24h) begin
            if (tod_q.hour == '0) begin
                hours = NOON;
            end else if (tod_q.hour > NOON) begin
                hours = tod_q.hour - NOON;
            end
        end
    end

`ifdef CLOCK_ALARM_EN
    logic [HOUR_W-1:0] alarm_h_q;
    logic [MIN_W-1:0]  alarm_m_q;
    logic              alarm_fire_q;
    tod_t              alarm_tod;

    assign alarm_tod  = '{hour: alarm_h_q, min: alarm_m_q, sec: '0};
    assign alarm_fire = alarm_fire_q;

    // Alarm fires only when a real tick lands on hh:mm:00, never on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_h_q    <= '0;
            alarm_m_q    <= '0;
            alarm_fire_q <= 1'b0;
        end else begin
            if (alarm_wr) begin
                alarm_h_q <= alarm_hours;
                alarm_m_q <= alarm_minutes;
            end
            alarm_fire_q <= sec_tick && !load_take && alarm_arm &&
                            (tod_adv == alarm_tod);
        end
    end
`else
    logic alarm_unused;

    assign alarm_unused = ^{alarm_wr, alarm_hours, alarm_minutes, alarm_arm};
    assign alarm_fire   = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper (TICK_DIV=4, RESET_HOUR=0): a
// seconds-of-day reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_rtc_timekeeper;

    localparam int D  = 4;
    localparam int RH = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mode_24h;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic [5:0] load_seconds;
    logic       load_err;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       sec_tick;
    logic       alarm_wr;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_arm;
    logic       alarm_fire;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtc_timekeeper #(
        .TICK_DIV   (D),
        .RESET_HOUR (RH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .mode_24h      (mode_24h),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_hours    (load_hours),
        .load_minutes  (load_minutes),
        .load_seconds  (load_seconds),
        .load_err      (load_err),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .am_pm         (am_pm),
        .sec_tick      (sec_tick),
        .alarm_wr      (alarm_wr),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_arm     (alarm_arm),
        .alarm_fire    (alarm_fire)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time as seconds since midnight, prescaler as the number
    // of run cycles since the last clear.
    int tod, n_run, m_tick, m_err, m_fire, m_ready, al_h, al_m;
    int old_tick, acc, ok;
    bit live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            tod = RH * 3600; n_run = 0; m_tick = 0; m_err = 0; m_fire = 0;
            m_ready = 0; al_h = 0; al_m = 0; live = 1'b1;
        end else if (live) begin
            acc = (load_valid && m_ready != 0) ? 1 : 0;
            ok  = (int'(load_hours) <= 23 && int'(load_minutes) <= 59 &&
                   int'(load_seconds) <= 59) ? 1 : 0;
            old_tick = m_tick;
            m_err = 0;
            m_fire = 0;
            if (acc != 0 && ok != 0) begin
                tod = int'(load_hours) * 3600 + int'(load_minutes) * 60 + int'(load_seconds);
                n_run = 0;
                m_tick = 0;
            end else begin
                m_err = acc;
                if (old_tick != 0) begin
                    tod = (tod + 1) % 86400;
`ifdef CLOCK_ALARM_EN
                    m_fire = (alarm_arm && tod == al_h * 3600 + al_m * 60) ? 1 : 0;
`endif
                end
                if (run) begin
                    n_run++;
                    m_tick = (n_run % D == 0) ? 1 : 0;
                end else begin
                    m_tick = 0;
                end
            end
`ifdef CLOCK_ALARM_EN
            if (alarm_wr) begin
                al_h = int'(alarm_hours);
                al_m = int'(alarm_minutes);
            end
`endif
            m_ready = 1;
        end
    end

    // Compare every output against the model away from the active edge.
    int h24, exp_h;
    always @(negedge clk) begin
        if (live) begin
            h24   = tod / 3600;
            exp_h = mode_24h ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
            check("hours",      int'(hours),      exp_h);
            check("minutes",    int'(minutes),    (tod / 60) % 60);
            check("seconds",    int'(seconds),    tod % 60);
            check("am_pm",      int'(am_pm),      (h24 >= 12) ? 1 : 0);
            check("sec_tick",   int'(sec_tick),   m_tick);
            check("load_ready", int'(load_ready), m_ready);
            check("load_err",   int'(load_err),   m_err);
            check("alarm_fire", int'(alarm_fire), m_fire);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a load in the current cycle and hold it across one edge.
    task automatic do_load(input int h, input int m, input int s);
        load_valid   = 1'b1;
        load_hours   = 5'(h);
        load_minutes = 6'(m);
        load_seconds = 6'(s);
        cyc();
        load_valid   = 1'b0;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (!sec_tick && k < 50) begin
            cyc();
            k++;
        end
        check("tick_wait", int'(sec_tick), 1);
    endtask

    task automatic check_time(input string tag, input int h, input int m,
                              input int s, input int pm);
        check({tag, "_h"},  int'(hours),   h);
        check({tag, "_m"},  int'(minutes), m);
        check({tag, "_s"},  int'(seconds), s);
        check({tag, "_pm"}, int'(am_pm),   pm);
    endtask

    int k;
    int exp_fire;

    initial begin
`ifdef CLOCK_ALARM_EN
        exp_fire = 1;
`else
        exp_fire = 0;
`endif
        rst = 1'b1; run = 1'b1; mode_24h = 1'b0; load_valid = 1'b0;
        load_hours = '0; load_minutes = '0; load_seconds = '0;
        alarm_wr = 1'b0; alarm_hours = '0; alarm_minutes = '0; alarm_arm = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Cycle after reset: 12:00:00 AM in 12h mode, no pulses, not ready.
        check_time("reset", 12, 0, 0, 0);
        check("reset_tick",  int'(sec_tick),   0);
        check("reset_ready", int'(load_ready), 0);
        cyc();
        check("ready_after", int'(load_ready), 1);

        // 11:59:59 -> noon.
        do_load(11, 59, 59);
        wait_tick();
        cyc();
        check_time("noon12", 12, 0, 0, 1);
        mode_24h = 1'b1;
        #1;
        check_time("noon24", 12, 0, 0, 1);

        // 23:59:59 -> midnight.
        do_load(23, 59, 59);
        wait_tick();
        cyc();
        check_time("mid24", 0, 0, 0, 0);
        mode_24h = 1'b0;
        #1;
        check_time("mid12", 12, 0, 0, 0);

        // Tick period, then a 3-cycle freeze.
        wait_tick();
        k = 0;
        do begin
            cyc();
            k++;
        end while (!sec_tick && k < 20);
        check("tick_period", k, 4);
        run = 1'b0;
        k = 0;
        do begin
            cyc();
            k++;
            if (k == 3) run = 1'b1;
        end while (!sec_tick && k < 30);
        check("tick_delay", k, 7);

        // Out-of-range load: one error pulse.
        mode_24h = 1'b1;
        do_load(24, 0, 0);
        check("err_pulse", int'(load_err), 1);
        cyc();
        check("err_clear", int'(load_err), 0);

        // Load coincident with a tick: loaded value, no increment.
        wait_tick();
        do_load(5, 6, 7);
        check_time("coinc", 5, 6, 7, 0);
        check("coinc_tick", int'(sec_tick), 0);

        // Alarm at 07:30, armed then disarmed.
        alarm_wr = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_arm = 1'b1;
        cyc();
        alarm_wr = 1'b0;
        do_load(7, 29, 59);
        wait_tick();
        cyc();
        check("alarm_armed", int'(alarm_fire), exp_fire);
        cyc();
        check("alarm_once", int'(alarm_fire), 0);
        alarm_arm = 1'b0;
        do_load(7, 29, 59);
        wait_tick();
        cyc();
        check("alarm_disarmed", int'(alarm_fire), 0);

        // Randomized traffic against the model.
        alarm_arm = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            run      = ($urandom_range(0, 4) != 0);
            mode_24h = 1'($urandom_range(0, 1));
            load_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: begin
                    load_hours   = 5'($urandom);
                    load_minutes = 6'($urandom);
                    load_seconds = 6'($urandom);
                end
                1: begin
                    load_hours   = 5'(al_h);
                    load_minutes = 6'((al_m + 59) % 60);
                    load_seconds = 6'd59;
                end
                default: begin
                    load_hours   = 5'($urandom_range(0, 23));
                    load_minutes = 6'($urandom_range(55, 59));
                    load_seconds = 6'($urandom_range(55, 59));
                end
            endcase
            alarm_wr      = ($urandom_range(0, 39) == 0);
            alarm_hours   = 5'($urandom_range(0, 23));
            alarm_minutes = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 19) == 0) alarm_arm = ~alarm_arm;
            cyc();
        end
        rst = 1'b0;
        load_valid = 1'b0;
        alarm_wr = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clock cycles per second (legal range 1..2^24).
REQ-002 SHALL have parameter RESET_HOUR, default 0: internal 24h hour loaded at reset (0..23).
REQ-003 SHALL have port clk, input, 1: single clock; all logic clocked on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port run, input, 1: 1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-006 SHALL have port mode_24h, input, 1: 1 = 24h display; 0 = 12h display with am_pm.
REQ-007 SHALL have port load_valid, input, 1: time-load request.
REQ-008 SHALL have port load_ready, output, 1: load accepted when valid and ready are both high.
REQ-009 SHALL have port load_hours, input, 5: load hour in internal 24h form (0..23).
REQ-010 SHALL have ports load_minutes and load_seconds, input, 6 each: load values (0..59).
REQ-011 SHALL have port load_err, output, 1: one-cycle pulse when a handshake carries an out-of-range field.
REQ-012 SHALL have port hours, output, 5: displayed hour (12h: 1..12; 24h: 0..23).
REQ-013 SHALL have ports minutes and seconds, output, 6 each: displayed time.
REQ-014 SHALL have port am_pm, output, 1: 0 = AM, 1 = PM; valid in both modes.
REQ-015 SHALL have port sec_tick, output, 1: one-cycle pulse on each second advance.
REQ-016 SHALL have ports alarm_wr (in, 1), alarm_hours (in, 5), alarm_minutes (in, 6), alarm_arm (in, 1) and alarm_fire (out, 1).

Function
REQ-017 SHALL keep time internally as 24h hour/min/sec registers; displayed outputs are a combinational mapping of those registers.
REQ-018 SHALL, with run=1, count prescaler cycles 0..TICK_DIV-1 and assert sec_tick in the cycle the count wraps; TICK_DIV=1 ticks every cycle.
REQ-019 SHALL advance the time on sec_tick, updating the registers at that edge (visible in the next cycle): sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
REQ-020 SHALL map the 12h display as: internal 0 -> 12 AM; 1..11 -> AM; 12 -> 12 PM; 13..23 -> hour-12 PM.
REQ-021 SHALL map the 24h display as hours = internal hour, with am_pm = (hour >= 12).
REQ-022 SHALL take effect the same cycle on a mode_24h change, without altering internal time.
REQ-023 SHALL hold load_ready=1 in every cycle except reset.
REQ-024 SHALL, on an accepted load, write all three fields at that edge, clear the prescaler and suppress any coincident tick (load wins).
REQ-025 SHALL leave time unchanged on a load with hours>23 or minutes/seconds>59, pulse load_err the next cycle, and not disturb the prescaler.
REQ-026 SHALL, with run=0, hold the prescaler count and keep sec_tick low; loads remain accepted.

Reset
REQ-027 SHALL apply the following on rst=1 at a clock edge: internal time = RESET_HOUR:00:00; prescaler = 0; sec_tick, load_err and alarm_fire = 0; alarm registers = 0, disarmed.
REQ-028 SHALL let rst override any concurrent load, tick or alarm write.
REQ-029 SHALL hold outputs at their reset values for the whole cycle following reset, with no pulses.

Configuration
REQ-030 SHALL compile alarm logic only when CLOCK_ALARM_EN is defined.
REQ-031 SHALL, with CLOCK_ALARM_EN: latch alarm_hours/alarm_minutes when alarm_wr=1; pulse alarm_fire for one cycle on the tick that makes the time equal alarm hh:mm:00 while alarm_arm=1.
REQ-032 SHALL, without CLOCK_ALARM_EN: keep every alarm port present, ignore alarm inputs and tie alarm_fire to 0.

Structure
REQ-033 SHALL keep SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, the field widths and a time-of-day struct typedef in shared package rtc_pkg.
REQ-034 SHALL implement the prescaler as sub-module rtc_prescaler (run and clear inputs, tick output; count width $clog2(TICK_DIV)).

Verification
REQ-035 SHALL verify: reset with RESET_HOUR=0, mode_24h=0 -> hours=12, min=0, sec=0, am_pm=0.
REQ-036 SHALL verify: load 11:59:59 then one tick -> 12h display 12:00:00 PM; 24h display 12:00:00, am_pm=1.
REQ-037 SHALL verify: load 23:59:59 then one tick -> 24h 00:00:00; 12h 12:00:00 AM.
REQ-038 SHALL verify: TICK_DIV=4, run=1 -> sec_tick every 4th cycle; run=0 for 3 cycles -> tick delayed by exactly 3.
REQ-039 SHALL verify: load hours=24 -> time unchanged, load_err pulses once; a valid load coincident with a tick -> loaded value, no increment.
REQ-040 SHALL verify: with CLOCK_ALARM_EN, alarm 07:30, arm=1, load 07:29:59 then one tick -> alarm_fire pulses one cycle; with alarm_arm=0 no pulse; macro undefined -> alarm_fire stays 0.
